serial_ripple_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: d = a_in - b_in - bw_in, built from one

---
 rtl/serial_ripple_subtractor.sv | 112 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: d = a_in - b_in - bw_in, one bit per clock, LSB first.
// A single full-subtractor cell is reused; results load on the final bit edge.
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bw_in,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic a_bit, b_bit, diff_bit, br_next;

  // Operands stay unshifted so their sign bits remain available for ovf.
  assign a_bit    = a_q[cnt_q];
  assign b_bit    = b_q[cnt_q];
  assign diff_bit = a_bit ^ b_bit ^ br_q;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StShift;
          a_d     = a_in;
          b_d     = b_in;
          br_d    = bw_in;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // MSB-in shift: after WIDTH steps bit 0 sits at res[0].
        res_d = {diff_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d = StDone;
          d_d     = {diff_bit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_bit ^ a_q[WIDTH-1]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4): directed cases,
// handshake/reset corner cases, exhaustive sweep and random operations.
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bw_in;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  int           n_checks;
  int           n_errors;
  logic [W-1:0] prev_d;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .bw_in (bw_in),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ovf, bout, d} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bw);
    int           r;
    logic [W-1:0] dd;
    logic         bo;
    logic         ov;
    r  = int'(a) - int'(b) - int'(bw);
    bo = (r < 0);
    dd = W'(r);
    ov = (a[W-1] != b[W-1]) && (dd[W-1] != a[W-1]);
    return {ov, bo, dd};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bw);
    logic [W+1:0] e;
    int           nbusy;
    int           n;
    e = model(a, b, bw);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    bw_in = bw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    bw_in = 1'($urandom);
    check("hold_d", d, prev_d);
    nbusy = 0;
    n     = 0;
    while (!done && n < 3 * W) begin
      if (busy) nbusy++;
      n++;
      @(negedge clk);
    end
    check("done", done, 1);
    check("busy_cycles", nbusy, W);
    check("busy_at_done", busy, 0);
    check("d", d, e[W-1:0]);
    check("bout", bout, e[W]);
    check("ovf", ovf, e[W+1]);
    prev_d = e[W-1:0];
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  initial begin
    int n;
    int dones;
    n_checks = 0;
    n_errors = 0;
    prev_d   = '0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    bw_in    = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Directed values with hand-computed results.
    run_op(4'b0101, 4'b0011, 1'b0);
    check("c1_d", d, 4'b0010);
    run_op(4'b0000, 4'b0001, 1'b0);
    check("c2a", {ovf, bout, d}, 6'b01_1111);
    run_op(4'b1000, 4'b0001, 1'b0);
    check("c2b", {ovf, bout, d}, 6'b10_0111);
    run_op(4'b0100, 4'b0101, 1'b1);
    check("c3a", {ovf, bout, d}, 6'b01_1110);
    run_op(4'b1111, 4'b1111, 1'b1);
    check("c3b", {bout, d}, 5'b1_1111);

    // Start while busy is ignored; start held in DONE is accepted back-to-back.
    @(negedge clk);
    a_in  = 4'b0101;
    b_in  = 4'b0011;
    bw_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c4_busy1", busy, 1);
    @(negedge clk);
    start = 1'b1;
    a_in  = 4'b1111;
    b_in  = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    a_in  = '0;
    n = 0;
    while (!done && n < 3 * W) begin
      n++;
      @(negedge clk);
    end
    check("c4_done1", done, 1);
    check("c4_op1", {ovf, bout, d}, 6'b00_0010);
    start = 1'b1;
    a_in  = 4'b1001;
    b_in  = 4'b0100;
    bw_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 3 * W) begin
      n++;
      @(negedge clk);
    end
    check("c4_period", n, W + 1);
    check("c4_op2", {ovf, bout, d}, 6'b10_0101);
    prev_d = 4'b0101;
    @(negedge clk);
    check("c4_done_pulse", done, 0);

    // Reset in the 3rd SHIFT cycle clears everything at once.
    @(negedge clk);
    a_in  = 4'b0110;
    b_in  = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("c5_d", d, 0);
    check("c5_bout", bout, 0);
    check("c5_ovf", ovf, 0);
    check("c5_busy", busy, 0);
    check("c5_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (3 * W) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("c5_no_done", dones, 0);
    prev_d = '0;
    run_op(4'b0110, 4'b0010, 1'b0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bw = 0; bw < 2; bw++) begin
          run_op(W'(a), W'(b), 1'(bw));
        end
      end
    end

    // Random operations.
    repeat (100) run_op(W'($urandom), W'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
